// File: rtl/cp0_pkg.sv
// CP0 register numbering, write masks, bit positions and reset constants.
package cp0_pkg;

    localparam logic [4:0] R_INDEX    = 5'd0;
    localparam logic [4:0] R_RANDOM   = 5'd1;
    localparam logic [4:0] R_ENTRYLO0 = 5'd2;
    localparam logic [4:0] R_ENTRYLO1 = 5'd3;
    localparam logic [4:0] R_CONTEXT  = 5'd4;
    localparam logic [4:0] R_PAGEMASK = 5'd5;
    localparam logic [4:0] R_WIRED    = 5'd6;
    localparam logic [4:0] R_BADVADDR = 5'd8;
    localparam logic [4:0] R_COUNT    = 5'd9;
    localparam logic [4:0] R_ENTRYHI  = 5'd10;
    localparam logic [4:0] R_COMPARE  = 5'd11;
    localparam logic [4:0] R_STATUS   = 5'd12;
    localparam logic [4:0] R_CAUSE    = 5'd13;
    localparam logic [4:0] R_EPC      = 5'd14;
    localparam logic [4:0] R_PRID     = 5'd15;
    localparam logic [4:0] R_CONFIG   = 5'd16;
    localparam logic [4:0] R_ERROREPC = 5'd30;

    // Register lookups are keyed on {regnum, sel}
    localparam logic [7:0] K_INDEX    = {R_INDEX,    3'd0};
    localparam logic [7:0] K_RANDOM   = {R_RANDOM,   3'd0};
    localparam logic [7:0] K_ENTRYLO0 = {R_ENTRYLO0, 3'd0};
    localparam logic [7:0] K_ENTRYLO1 = {R_ENTRYLO1, 3'd0};
    localparam logic [7:0] K_CONTEXT  = {R_CONTEXT,  3'd0};
    localparam logic [7:0] K_PAGEMASK = {R_PAGEMASK, 3'd0};
    localparam logic [7:0] K_WIRED    = {R_WIRED,    3'd0};
    localparam logic [7:0] K_BADVADDR = {R_BADVADDR, 3'd0};
    localparam logic [7:0] K_COUNT    = {R_COUNT,    3'd0};
    localparam logic [7:0] K_ENTRYHI  = {R_ENTRYHI,  3'd0};
    localparam logic [7:0] K_COMPARE  = {R_COMPARE,  3'd0};
    localparam logic [7:0] K_STATUS   = {R_STATUS,   3'd0};
    localparam logic [7:0] K_CAUSE    = {R_CAUSE,    3'd0};
    localparam logic [7:0] K_EPC      = {R_EPC,      3'd0};
    localparam logic [7:0] K_PRID     = {R_PRID,     3'd0};
    localparam logic [7:0] K_EBASE    = {R_PRID,     3'd1};
    localparam logic [7:0] K_CONFIG   = {R_CONFIG,   3'd0};
    localparam logic [7:0] K_CONFIG1  = {R_CONFIG,   3'd1};
    localparam logic [7:0] K_ERROREPC = {R_ERROREPC, 3'd0};

    localparam logic [31:0] M_INDEX    = 32'h0000_003F;
    localparam logic [31:0] M_TLBP     = 32'h8000_003F;
    localparam logic [31:0] M_ENTRYLO  = 32'h03FF_FFFF;
    localparam logic [31:0] M_CONTEXT  = 32'hFF80_0000;
    localparam logic [31:0] M_PAGEMASK = 32'h1FFF_E000;
    localparam logic [31:0] M_WIRED    = 32'h0000_003F;
    localparam logic [31:0] M_ENTRYHI  = 32'hFFFF_E0FF;
    localparam logic [31:0] M_STATUS   = 32'h1040_FF17;
    localparam logic [31:0] M_CAUSE    = 32'h0000_0300;
    localparam logic [31:0] M_EBASE    = 32'h3FFF_F000;
    localparam logic [31:0] M_CONFIG   = 32'h0000_0007;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_ERL = 2;
    localparam int ST_IM  = 8;
    localparam int CA_EXC = 2;
    localparam int CA_IP  = 8;
    localparam int CA_IP7 = 15;
    localparam int CA_TI  = 30;
    localparam int CA_BD  = 31;

    localparam logic [31:0] STATUS_RST  = 32'h1040_0004;
    localparam logic [31:0] EBASE_RST   = 32'h8000_0000;
    localparam logic [31:0] PRID_VAL    = 32'h00FF_0000;
    localparam logic [31:0] CONFIG_RST  = 32'h8000_0083;
    localparam logic [31:0] CONFIG1_BASE = 32'h0000_0000;

    function automatic logic [31:0] mwr(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [31:0] msk);
        return (old & ~msk) | (dat & msk);
    endfunction

    // MMUSize field holds entries-1 in bits 30:25
    function automatic logic [31:0] config1_val(input int entries);
        return CONFIG1_BASE | ({26'd0, 6'(entries - 1)} << 25);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count prescaler, Count/Compare registers and timer-interrupt flag; loads take effect next cycle.
// TI generation is present only when CP0_TIMER_INT_EN is defined.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cnt_wr_vld_i,
    input  logic [31:0] cnt_wr_dat_i,
    input  logic        cmp_wr_vld_i,
    input  logic [31:0] cmp_wr_dat_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;
    logic          tick;

    assign tick = (presc_q == PW'(COUNT_DIV - 1));

    always_comb begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        count_d   = count_q + {31'd0, tick};
        compare_d = compare_q;
        if (cnt_wr_vld_i) begin
            count_d = cnt_wr_dat_i;
            presc_d = '0;
        end
        if (cmp_wr_vld_i) compare_d = cmp_wr_dat_i;
`ifdef CP0_TIMER_INT_EN
        ti_d = ti_q;
        if (tick && (count_d == compare_q)) ti_d = 1'b1;
        // a Compare write always wins over a same-cycle match
        if (cmp_wr_vld_i) ti_d = 1'b0;
`else
        ti_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;
endmodule

// File: rtl/cp0_regfile_mp.sv
// Multi-port MIPS32 CP0 register file: masked mtc0 writes (next cycle), combinational mfc0 reads,
// exception/ERET, TLBR/TLBP updates, registered int_req. Timer interrupt under CP0_TIMER_INT_EN.
module cp0_regfile_mp
    import cp0_pkg::*;
#(
    parameter int NUM_WR      = 2,
    parameter int NUM_RD      = 2,
    parameter int TLB_ENTRIES = 32,
    parameter int COUNT_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*5-1:0]  wr_addr,
    input  logic [NUM_WR*3-1:0]  wr_sel,
    input  logic [NUM_WR*32-1:0] wr_data,
    input  logic [NUM_RD*5-1:0]  rd_addr,
    input  logic [NUM_RD*3-1:0]  rd_sel,
    output logic [NUM_RD*32-1:0] rd_data,
    input  logic [5:0]           hw_int,
    input  logic                 exc_valid,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          exc_pc,
    input  logic                 exc_bd,
    input  logic                 exc_bad_valid,
    input  logic [31:0]          exc_badvaddr,
    input  logic                 eret,
    input  logic                 tlbr_valid,
    input  logic [31:0]          tlbr_entryhi,
    input  logic [31:0]          tlbr_lo0,
    input  logic [31:0]          tlbr_lo1,
    input  logic [31:0]          tlbr_pagemask,
    input  logic                 tlbp_valid,
    input  logic [31:0]          tlbp_index,
    output logic [31:0]          status,
    output logic [31:0]          cause,
    output logic [31:0]          epc,
    output logic [31:0]          ebase,
    output logic [31:0]          entryhi,
    output logic [31:0]          random,
    output logic                 int_req
);
    localparam logic [31:0] RAND_TOP = 32'(TLB_ENTRIES - 1);

    logic [31:0] index_q, index_d, random_q, random_d, lo0_q, lo0_d, lo1_q, lo1_d;
    logic [31:0] context_q, context_d, pagemask_q, pagemask_d, wired_q, wired_d;
    logic [31:0] badvaddr_q, badvaddr_d, entryhi_q, entryhi_d, status_q, status_d;
    logic [31:0] cause_q, cause_d, epc_q, epc_d, ebase_q, ebase_d, cfg_q, cfg_d;
    logic [31:0] errorepc_q, errorepc_d;
    logic        int_req_q, int_req_d;

    logic [31:0] count_v, compare_v, cause_v, wd, cnt_wdat, cmp_wdat;
    logic [7:0]  wkey;
    logic        cnt_wr, cmp_wr, ti;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .cnt_wr_vld_i (cnt_wr),
        .cnt_wr_dat_i (cnt_wdat),
        .cmp_wr_vld_i (cmp_wr),
        .cmp_wr_dat_i (cmp_wdat),
        .count_o      (count_v),
        .compare_o    (compare_v),
        .ti_o         (ti)
    );

    always_comb begin
        cause_v         = cause_q;
        cause_v[CA_TI]  = ti;
        cause_v[CA_IP7] = cause_q[CA_IP7] | ti;
    end

    always_comb begin
        index_d = index_q;  lo0_d = lo0_q;  lo1_d = lo1_q;  context_d = context_q;
        pagemask_d = pagemask_q;  wired_d = wired_q;  badvaddr_d = badvaddr_q;
        entryhi_d = entryhi_q;  status_d = status_q;  epc_d = epc_q;  ebase_d = ebase_q;
        cfg_d = cfg_q;  errorepc_d = errorepc_q;
        cnt_wr = 1'b0;  cnt_wdat = '0;  cmp_wr = 1'b0;  cmp_wdat = '0;
        wd = '0;  wkey = '0;
        random_d = ((random_q == wired_q) || (random_q == '0)) ? RAND_TOP : random_q - 32'd1;
        cause_d = cause_q;
        cause_d[CA_IP+7:CA_IP+2] = hw_int;

        // later ports overwrite earlier ones, giving the higher index priority
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                wd   = wr_data[p*32 +: 32];
                wkey = {wr_addr[p*5 +: 5], wr_sel[p*3 +: 3]};
                case (wkey)
                    K_INDEX:    index_d    = mwr(index_d, wd, M_INDEX);
                    K_ENTRYLO0: lo0_d      = mwr(lo0_d, wd, M_ENTRYLO);
                    K_ENTRYLO1: lo1_d      = mwr(lo1_d, wd, M_ENTRYLO);
                    K_CONTEXT:  context_d  = mwr(context_d, wd, M_CONTEXT);
                    K_PAGEMASK: pagemask_d = mwr(pagemask_d, wd, M_PAGEMASK);
                    K_WIRED: begin
                        wired_d  = mwr(wired_d, wd, M_WIRED);
                        random_d = RAND_TOP;
                    end
                    K_COUNT:    begin cnt_wr = 1'b1; cnt_wdat = wd; end
                    K_ENTRYHI:  entryhi_d  = mwr(entryhi_d, wd, M_ENTRYHI);
                    K_COMPARE:  begin cmp_wr = 1'b1; cmp_wdat = wd; end
                    K_STATUS:   status_d   = mwr(status_d, wd, M_STATUS);
                    K_CAUSE:    cause_d    = mwr(cause_d, wd, M_CAUSE);
                    K_EPC:      epc_d      = wd;
                    K_EBASE:    ebase_d    = mwr(ebase_d, wd, M_EBASE);
                    K_CONFIG:   cfg_d      = mwr(cfg_d, wd, M_CONFIG);
                    K_ERROREPC: errorepc_d = wd;
                    default: ;
                endcase
            end
        end

        if (tlbr_valid) begin
            entryhi_d  = mwr(entryhi_d, tlbr_entryhi, M_ENTRYHI);
            lo0_d      = mwr(lo0_d, tlbr_lo0, M_ENTRYLO);
            lo1_d      = mwr(lo1_d, tlbr_lo1, M_ENTRYLO);
            pagemask_d = mwr(pagemask_d, tlbr_pagemask, M_PAGEMASK);
        end
        if (tlbp_valid) index_d = mwr(index_d, tlbp_index, M_TLBP);

        if (exc_valid) begin
            // nested exceptions keep the original EPC/BD
            if (!status_q[ST_EXL]) begin
                epc_d         = exc_bd ? exc_pc - 32'd4 : exc_pc;
                cause_d[CA_BD] = exc_bd;
            end
            cause_d[CA_EXC+4:CA_EXC] = exc_code;
            status_d[ST_EXL]         = 1'b1;
            if (exc_bad_valid) badvaddr_d = exc_badvaddr;
        end else if (eret) begin
            if (status_q[ST_ERL]) status_d[ST_ERL] = 1'b0;
            else                  status_d[ST_EXL] = 1'b0;
        end

        int_req_d = status_q[ST_IE] & ~status_q[ST_EXL] & ~status_q[ST_ERL]
                  & (|(cause_v[CA_IP+7:CA_IP] & status_q[ST_IM+7:ST_IM]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_q <= '0;  random_q <= RAND_TOP;  lo0_q <= '0;  lo1_q <= '0;
            context_q <= '0;  pagemask_q <= '0;  wired_q <= '0;  badvaddr_q <= '0;
            entryhi_q <= '0;  status_q <= STATUS_RST;  cause_q <= '0;  epc_q <= '0;
            ebase_q <= EBASE_RST;  cfg_q <= CONFIG_RST;  errorepc_q <= '0;  int_req_q <= 1'b0;
        end else begin
            index_q <= index_d;  random_q <= random_d;  lo0_q <= lo0_d;  lo1_q <= lo1_d;
            context_q <= context_d;  pagemask_q <= pagemask_d;  wired_q <= wired_d;
            badvaddr_q <= badvaddr_d;  entryhi_q <= entryhi_d;  status_q <= status_d;
            cause_q <= cause_d;  epc_q <= epc_d;  ebase_q <= ebase_d;  cfg_q <= cfg_d;
            errorepc_q <= errorepc_d;  int_req_q <= int_req_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            case ({rd_addr[r*5 +: 5], rd_sel[r*3 +: 3]})
                K_INDEX:    rd_data[r*32 +: 32] = index_q;
                K_RANDOM:   rd_data[r*32 +: 32] = random_q;
                K_ENTRYLO0: rd_data[r*32 +: 32] = lo0_q;
                K_ENTRYLO1: rd_data[r*32 +: 32] = lo1_q;
                K_CONTEXT:  rd_data[r*32 +: 32] = context_q;
                K_PAGEMASK: rd_data[r*32 +: 32] = pagemask_q;
                K_WIRED:    rd_data[r*32 +: 32] = wired_q;
                K_BADVADDR: rd_data[r*32 +: 32] = badvaddr_q;
                K_COUNT:    rd_data[r*32 +: 32] = count_v;
                K_ENTRYHI:  rd_data[r*32 +: 32] = entryhi_q;
                K_COMPARE:  rd_data[r*32 +: 32] = compare_v;
                K_STATUS:   rd_data[r*32 +: 32] = status_q;
                K_CAUSE:    rd_data[r*32 +: 32] = cause_v;
                K_EPC:      rd_data[r*32 +: 32] = epc_q;
                K_PRID:     rd_data[r*32 +: 32] = PRID_VAL;
                K_EBASE:    rd_data[r*32 +: 32] = ebase_q;
                K_CONFIG:   rd_data[r*32 +: 32] = cfg_q;
                K_CONFIG1:  rd_data[r*32 +: 32] = config1_val(TLB_ENTRIES);
                K_ERROREPC: rd_data[r*32 +: 32] = errorepc_q;
                default:    rd_data[r*32 +: 32] = '0;
            endcase
        end
    end

    assign status  = status_q;
    assign cause   = cause_v;
    assign epc     = epc_q;
    assign ebase   = ebase_q;
    assign entryhi = entryhi_q;
    assign random  = random_q;
    assign int_req = int_req_q;
endmodule

// File: tb/tb_cp0_regfile_mp.sv
// Directed bench for cp0_regfile_mp with default parameters; timer expectations follow CP0_TIMER_INT_EN.
module tb_cp0_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [5:0]  wr_sel;
    logic [63:0] wr_data;
    logic [9:0]  rd_addr;
    logic [5:0]  rd_sel;
    logic [63:0] rd_data;
    logic [5:0]  hw_int;
    logic        exc_valid, exc_bd, exc_bad_valid, eret, tlbr_valid, tlbp_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, exc_badvaddr, tlbr_entryhi, tlbr_lo0, tlbr_lo1, tlbr_pagemask, tlbp_index;
    logic [31:0] status, cause, epc, ebase, entryhi, random;
    logic        int_req;

    int errors = 0;
    int checks = 0;

`ifdef CP0_TIMER_INT_EN
    localparam logic [31:0] EXP_TI_CAUSE = 32'h4000_8000;
    localparam logic [31:0] EXP_TI_INT   = 32'd1;
`else
    localparam logic [31:0] EXP_TI_CAUSE = 32'h0000_0000;
    localparam logic [31:0] EXP_TI_INT   = 32'd0;
`endif

    always #5 clk = ~clk;

    cp0_regfile_mp dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
        .hw_int(hw_int), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_bd(exc_bd), .exc_bad_valid(exc_bad_valid), .exc_badvaddr(exc_badvaddr),
        .eret(eret), .tlbr_valid(tlbr_valid), .tlbr_entryhi(tlbr_entryhi),
        .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1), .tlbr_pagemask(tlbr_pagemask),
        .tlbp_valid(tlbp_valid), .tlbp_index(tlbp_index), .status(status), .cause(cause),
        .epc(epc), .ebase(ebase), .entryhi(entryhi), .random(random), .int_req(int_req)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        wr_en[p]           = 1'b1;
        wr_addr[p*5 +: 5]  = a;
        wr_sel[p*3 +: 3]   = s;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rdchk(input string tag, input logic [4:0] a, input logic [2:0] s,
                         input logic [31:0] exp);
        rd_addr[4:0] = a;
        rd_sel[2:0]  = s;
        #1;
        chk(tag, rd_data[31:0], exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        wr_en = '0; wr_addr = '0; wr_sel = '0; wr_data = '0; rd_addr = '0; rd_sel = '0;
        hw_int = '0; exc_valid = 0; exc_bd = 0; exc_bad_valid = 0; eret = 0; exc_code = '0;
        exc_pc = '0; exc_badvaddr = '0; tlbr_valid = 0; tlbp_valid = 0; tlbr_entryhi = '0;
        tlbr_lo0 = '0; tlbr_lo1 = '0; tlbr_pagemask = '0; tlbp_index = '0;
        do_reset();

        chk("rst_random", random, 32'd31);
        chk("rst_status", status, 32'h1040_0004);
        chk("rst_ebase", ebase, 32'h8000_0000);
        chk("rst_int_req", {31'd0, int_req}, 32'd0);
        chk("rst_cause", cause, 32'd0);
        for (int i = 0; i < 31; i++) step();
        chk("random_at_0", random, 32'd0);
        step();
        chk("random_wrap", random, 32'd31);
        for (int i = 0; i < 8; i++) step();
        chk("random_40", random, 32'd23);

        // Wired write; read in the write cycle must see the old value
        wr(0, 5'd6, 3'd0, 32'd8);
        rdchk("wired_rd_old", 5'd6, 3'd0, 32'd0);
        step();
        wr_en = '0;
        chk("random_after_wired", random, 32'd31);
        rdchk("wired_rd_new", 5'd6, 3'd0, 32'd8);
        for (int i = 0; i < 23; i++) step();
        chk("random_at_wired", random, 32'd8);
        step();
        chk("random_reload_wired", random, 32'd31);

        wr(0, 5'd12, 3'd0, 32'h0000_0001);
        wr(1, 5'd12, 3'd0, 32'h0000_FF01);
        step();
        wr_en = '0;
        chk("status_port1_wins", status, 32'h0000_FF01);
        hw_int = 6'h01;
        step();
        chk("cause_ip2", cause, 32'h0000_0400);
        chk("int_req_lat1", {31'd0, int_req}, 32'd0);
        step();
        chk("int_req_lat2", {31'd0, int_req}, 32'd1);

        hw_int = '0;
        do_reset();
        exc_valid = 1; exc_pc = 32'hBFC0_0104; exc_bd = 1; exc_code = 5'd8;
        exc_bad_valid = 1; exc_badvaddr = 32'hDEAD_BEEF;
        step();
        chk("exc1_epc", epc, 32'hBFC0_0100);
        chk("exc1_cause", cause, 32'h8000_0020);
        chk("exc1_status", status, 32'h1040_0006);
        rdchk("exc1_badvaddr", 5'd8, 3'd0, 32'hDEAD_BEEF);
        exc_pc = 32'h0000_0200; exc_bd = 0; exc_code = 5'd4; exc_bad_valid = 0;
        step();
        exc_valid = 0;
        chk("exc2_epc_kept", epc, 32'hBFC0_0100);
        chk("exc2_cause", cause, 32'h8000_0010);
        eret = 1;
        step();
        chk("eret1_erl", status, 32'h1040_0002);
        step();
        eret = 0;
        chk("eret2_exl", status, 32'h1040_0000);
        exc_valid = 1; eret = 1; exc_pc = 32'h0000_0300; exc_bd = 0; exc_code = 5'd0;
        step();
        exc_valid = 0;
        chk("exc_eret_epc", epc, 32'h0000_0300);
        chk("exc_eret_status", status, 32'h1040_0002);
        chk("exc_eret_cause", cause, 32'h0000_0000);
        rdchk("exc3_badvaddr_kept", 5'd8, 3'd0, 32'hDEAD_BEEF);
        step();
        eret = 0;
        chk("eret3_exl", status, 32'h1040_0000);

        tlbr_valid = 1; tlbr_entryhi = 32'hFFFF_FFFF; tlbr_lo0 = 32'h1234_5678;
        tlbr_lo1 = 32'hFFFF_FFFF; tlbr_pagemask = 32'hFFFF_FFFF;
        wr(0, 5'd2, 3'd0, 32'h0000_0000);
        step();
        tlbr_valid = 0; wr_en = '0;
        chk("tlbr_entryhi", entryhi, 32'hFFFF_E0FF);
        rdchk("tlbr_lo0", 5'd2, 3'd0, 32'h0234_5678);
        rdchk("tlbr_lo1", 5'd3, 3'd0, 32'h03FF_FFFF);
        rdchk("tlbr_pagemask", 5'd5, 3'd0, 32'h1FFF_E000);
        tlbp_valid = 1; tlbp_index = 32'h8000_0005;
        step();
        tlbp_valid = 0;
        rdchk("tlbp_index", 5'd0, 3'd0, 32'h8000_0005);
        rdchk("config1", 5'd16, 3'd1, 32'h3E00_0000);
        rdchk("unmapped7", 5'd7, 3'd0, 32'h0000_0000);

        wr(0, 5'd15, 3'd0, 32'hFFFF_FFFF);
        wr(1, 5'd15, 3'd1, 32'hFFFF_FFFF);
        step();
        wr_en = '0;
        rdchk("prid_ro", 5'd15, 3'd0, 32'h00FF_0000);
        chk("ebase_masked", ebase, 32'hBFFF_F000);

        wr(0, 5'd12, 3'd0, 32'h0000_8001);
        step();
        wr_en = '0;
        chk("status_im7_ie", status, 32'h0000_8001);
        wr(0, 5'd9, 3'd0, 32'd0);
        wr(1, 5'd11, 3'd0, 32'd5);
        step();
        wr_en = '0;
        for (int i = 0; i < 9; i++) step();
        chk("ti_before_match", cause, 32'h0000_0000);
        rdchk("count_9", 5'd9, 3'd0, 32'd4);
        step();
        rdchk("count_10", 5'd9, 3'd0, 32'd5);
        chk("ti_at_match", cause, EXP_TI_CAUSE);
        step();
        chk("timer_int_req", {31'd0, int_req}, EXP_TI_INT);
        wr(0, 5'd11, 3'd0, 32'h0000_0100);
        step();
        wr_en = '0;
        chk("ti_cleared", {31'd0, cause[30]}, 32'd0);
        rdchk("compare_rd", 5'd11, 3'd0, 32'h0000_0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cp0_regfile_mp.md
Name: cp0_regfile_mp

Overview:
- Parametrised next-generation MIPS32 CP0 register file with N mtc0 write ports and M mfc0 read ports.
- Adds hardware Count prescaling, Count/Compare timer interrupt, a Random register that counts down, atomic exception entry and ERET, TLBR/TLBP update paths, and interrupt-request generation.
- Sits beside the commit stage. ALU and exception logic write here; fetch and exception logic consume the status outputs.

Parameters:
- NUM_WR, 2, number of mtc0 write ports; a higher index wins on conflict.
- NUM_RD, 2, number of combinational read ports.
- TLB_ENTRIES, 32, TLB size; Random reset/wrap value is TLB_ENTRIES-1 (power of 2, 4..64).
- COUNT_DIV, 2, clk cycles per Count increment (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  NUM_WR  per-port mtc0 strobe
- wr_addr  in  NUM_WR*5  register number
- wr_sel  in  NUM_WR*3  select
- wr_data  in  NUM_WR*32  data
- rd_addr  in  NUM_RD*5  read register number
- rd_sel  in  NUM_RD*3  read select
- rd_data  out  NUM_RD*32  read data
- hw_int  in  6  external interrupts, level, feeding IP[7:2]
- exc_valid  in  1  exception entry
- exc_code  in  5  ExcCode
- exc_pc  in  32  faulting PC
- exc_bd  in  1  faulting instruction is in a branch delay slot
- exc_bad_valid  in  1  load BadVAddr
- exc_badvaddr  in  32  bad address
- eret  in  1  ERET commit
- tlbr_valid  in  1  TLBR result
- tlbr_entryhi  in  32  TLBR EntryHi
- tlbr_lo0  in  32  TLBR EntryLo0
- tlbr_lo1  in  32  TLBR EntryLo1
- tlbr_pagemask  in  32  TLBR PageMask
- tlbp_valid  in  1  TLBP result strobe
- tlbp_index  in  32  TLBP Index value, P in bit 31
- status  out  32  Status register
- cause  out  32  Cause register
- epc  out  32  EPC register
- ebase  out  32  EBase register
- entryhi  out  32  EntryHi register
- random  out  32  Random register
- int_req  out  1  interrupt should be taken

Behaviour:
- Reset values:
  - Random = TLB_ENTRIES-1; Wired = Count = Compare = Cause = Context = PageMask = 0.
  - Status = 0x1040_0004 (CU0, BEV, ERL).
  - EBase = 0x8000_0000; PRId = 0x00FF_0000.
  - Config/Config1 constants from the package; Config1.MMUSize = TLB_ENTRIES-1.
  - All other registers are 0; int_req = 0.
- Register map:
  - 0 Index, 1 Random (read-only), 2 EntryLo0, 3 EntryLo1, 4 Context, 5 PageMask, 6 Wired, 8 BadVAddr (read-only), 9 Count, 10 EntryHi, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15/0 PRId (read-only), 15/1 EBase, 16/0 Config, 16/1 Config1 (read-only), 30 ErrorEPC.
  - Any other addr/sel reads 0; writes to it are ignored.
- Write rule: new = (old & ~MASK) | (data & MASK), with per-register masks from the package. Effective the next cycle.
- Reads are combinational. A read in the same cycle as a write returns the old value.
- Priority per register, lowest to highest: hardware update (Count tick, Random decrement, IP sampling), then mtc0 port 0..NUM_WR-1, then tlbr/tlbp, then exc_valid/eret.
- Count:
  - Prescaler counts 0..COUNT_DIV-1; Count increments by 1 when the prescaler wraps, modulo 2^32.
  - An mtc0 to Count loads the data and clears the prescaler.
- Random:
  - Decrements every cycle. When Random == Wired, or Random == 0, the next value is TLB_ENTRIES-1.
  - An mtc0 to Wired sets Random = TLB_ENTRIES-1 in the same update.
- Cause.IP[7:2]: each cycle, Cause.IP[7:2] = hw_int. Only IP[1:0] are software-writable.
- Exception entry (exc_valid):
  - If Status.EXL == 0, set EPC = exc_pc (exc_pc-4 if exc_bd) and Cause.BD = exc_bd.
  - Always set Cause.ExcCode = exc_code and Status.EXL = 1.
  - BadVAddr = exc_badvaddr when exc_bad_valid.
- eret:
  - If ERL is set, clear ERL; otherwise clear EXL.
  - exc_valid and eret in the same cycle: the exception wins and eret is ignored.
- tlbr_valid: loads EntryHi, EntryLo0, EntryLo1 and PageMask through their respective masks.
- tlbp_valid: Index = tlbp_index (P bit and index field).
- int_req is registered: int_req = Status.IE & ~EXL & ~ERL & |(Cause.IP & Status.IM), computed from the current register values. Latency is 1 cycle from the IP/Status change.

Optional Feature:
- Macro: CP0_TIMER_INT_EN.
- Defined:
  - When Count (post-update) == Compare and the prescaler wraps, set Cause.TI (bit 30).
  - IP7 = hw_int[5] | TI.
  - An mtc0 to Compare clears TI. A same-cycle match and Compare write leaves TI clear.
- Undefined: TI is always 0 and IP7 = hw_int[5].

Decomposition:
- Package cp0_pkg holds:
  - Register number and select localparams.
  - Per-register write masks.
  - Status/Cause bit-position localparams.
  - Reset constants for Status, EBase, PRId, Config and Config1.
- One sub-module, cp0_timer: Count prescaler, Count register, Compare match and TI flag, with a write-load interface.

Test Plan:
- Reset -> Random=31, Status=0x10400004, EBase=0x80000000, int_req=0. Hold 40 cycles -> Random walks 31..0 and wraps to 31.
- Wired=8 via port 0 -> Random=31 next cycle, then decrements to 8 and reloads to 31 on the following cycle.
- Port0 writes Status=0x1, port1 writes Status=0xFF01 in the same cycle -> Status IE=1, IM=0xFF (port 1 wins, masked). hw_int=0x01 -> int_req=1 two cycles later.
- exc_valid with exc_pc=0xBFC00104, exc_bd=1, code=8 -> EPC=0xBFC00100, BD=1, ExcCode=8, EXL=1. A second exception with exc_pc=0x200 -> EPC unchanged. eret -> ERL cleared first, EXL cleared on a second eret.
- Timer (macro defined), COUNT_DIV=2: Count=0, Compare=5 -> TI=1 after 10 cycles and int_req follows if IM7/IE are set. Write Compare=0x100 -> TI=0.
- tlbr_valid with lo0=0x12345678 -> EntryLo0 = masked value; EntryHi/PageMask from their own fields. A same-cycle mtc0 EntryLo0=0 loses.
